gpio_bank: RTL and testbench

- Parametrised successor to the fixed two-port gpi1/gpi2/gpo1/gpo2 I/O of the mipss top level.
- Provides NCH channels of W-bit inputs and outputs on a word-addressed, memory-mapped bus driven by the MIPS data path.
- Adds a 2-flop input synchroniser, atomic set/clear of outputs, per-bit edge detection, write-1-to-clear interrupt status and a single maskable irq line.

---
 rtl/gpio_bank.sv | 140 ++++++++++++++
 tb/tb_gpio_bank.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_bank.sv
// gpio_bank: NCH channels of W-bit inputs/outputs behind a word-addressed register bus,
// with edge-triggered W1C interrupt status. Define GPIO_DEBOUNCE_EN for input debouncing.
module gpio_bank #(
  parameter int unsigned NCH       = 2,
  parameter int unsigned W         = 32,
  parameter int unsigned AW        = 4,
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [31:0]       wd,
  output logic [31:0]       rd,
  input  logic [NCH*W-1:0]  gpi,
  output logic [NCH*W-1:0]  gpo,
  output logic              irq
);

  logic [31:0]    ch_idx;
  logic [2:0]     reg_idx;
  logic [31:0]    rd_ch [NCH];
  logic [NCH-1:0] irq_ch;

  assign ch_idx  = 32'(addr[AW-1:3]);
  assign reg_idx = addr[2:0];

  if (AW < 4 || (1 << (AW - 3)) < NCH || W < 1 || W > 32 ||
      DB_CYCLES < 1 || DB_CYCLES > 255) begin : g_bad_params
    $error("gpio_bank: illegal parameter combination");
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic         wr;
    logic [W-1:0] wdat;
    logic [W-1:0] dout_q, dout_d;
    logic [W-1:0] mask_q, edge_q, stat_q, stat_d;
    logic [W-1:0] sync1_q, sync2_q, prev_q, filt, evt;
    logic [31:0]  rdv;

    assign wr   = we && (ch_idx == 32'(c));
    assign wdat = wd[W-1:0];

    always_comb begin
      dout_d = dout_q;
      if (wr) begin
        case (reg_idx)
          3'd1:    dout_d = wdat;
          3'd2:    dout_d = dout_q | wdat;
          3'd3:    dout_d = dout_q & ~wdat;
          default: dout_d = dout_q;
        endcase
      end
    end

    assign evt = (edge_q & ~prev_q & filt) | (~edge_q & prev_q & ~filt);

    always_comb begin
      stat_d = stat_q;
      if (wr && reg_idx == 3'd6) stat_d = stat_q & ~wdat;
      // A new event beats a same-cycle W1C.
      stat_d = stat_d | evt;
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        sync1_q <= '0;
        sync2_q <= '0;
        prev_q  <= '0;
        dout_q  <= '0;
        mask_q  <= '0;
        edge_q  <= '0;
        stat_q  <= '0;
      end else begin
        sync1_q <= gpi[c*W +: W];
        sync2_q <= sync1_q;
        prev_q  <= filt;
        dout_q  <= dout_d;
        stat_q  <= stat_d;
        if (wr && reg_idx == 3'd4) mask_q <= wdat;
        if (wr && reg_idx == 3'd5) edge_q <= wdat;
      end
    end

`ifdef GPIO_DEBOUNCE_EN
    logic [W-1:0] filt_q;
    logic [7:0]   cnt_q [W];

    // filt follows sync2 only after DB_CYCLES consecutive cycles of disagreement.
    always_ff @(posedge clk) begin
      if (!rst) begin
        filt_q <= '0;
        for (int i = 0; i < W; i++) cnt_q[i] <= '0;
      end else begin
        for (int i = 0; i < W; i++) begin
          if (sync2_q[i] == filt_q[i]) begin
            cnt_q[i] <= '0;
          end else if (cnt_q[i] == 8'(DB_CYCLES - 1)) begin
            filt_q[i] <= sync2_q[i];
            cnt_q[i]  <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 8'd1;
          end
        end
      end
    end

    assign filt = filt_q;
`else
    assign filt = sync2_q;
`endif

    always_comb begin
      rdv = '0;
      case (reg_idx)
        3'd0:    rdv[W-1:0] = filt;
        3'd1:    rdv[W-1:0] = dout_q;
        3'd4:    rdv[W-1:0] = mask_q;
        3'd5:    rdv[W-1:0] = edge_q;
        3'd6:    rdv[W-1:0] = stat_q;
        default: rdv = '0;
      endcase
    end

    assign rd_ch[c]        = rdv;
    assign gpo[c*W +: W]   = dout_q;
    assign irq_ch[c]       = |(stat_q & mask_q);
  end

  // Out-of-range channels match nothing and read 0.
  always_comb begin
    rd = '0;
    for (int c = 0; c < NCH; c++) begin
      if (ch_idx == 32'(c)) rd = rd_ch[c];
    end
  end

  assign irq = |irq_ch;

endmodule

// File: tb/tb_gpio_bank.sv
// Bench for gpio_bank: directed vector table plus randomized traffic against a
// sample-history reference model.
module tb_gpio_bank;

  localparam int unsigned NCH = 2;
  localparam int unsigned W   = 32;
  localparam int unsigned AW  = 5;
  localparam int unsigned DB  = 4;
  localparam int unsigned GW  = NCH * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic [AW-1:0] addr;
  logic [31:0]   wd;
  logic [31:0]   rd;
  logic [GW-1:0] gpi;
  logic [GW-1:0] gpo;
  logic          irq;

  int checks = 0;
  int errors = 0;

  gpio_bank #(.NCH(NCH), .W(W), .AW(AW), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .we(we), .addr(addr), .wd(wd), .rd(rd),
    .gpi(gpi), .gpo(gpo), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [W-1:0]  m_dout [NCH];
  logic [W-1:0]  m_mask [NCH];
  logic [W-1:0]  m_edge [NCH];
  logic [W-1:0]  m_stat [NCH];
  logic [GW-1:0] m_filt;
  logic [GW-1:0] m_prev;
  logic [GW-1:0] hist [$];  // hist[0] = gpi sampled at the most recent edge

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_dout[c] = '0; m_mask[c] = '0; m_edge[c] = '0; m_stat[c] = '0;
    end
    m_filt = '0;
    m_prev = '0;
    hist.delete();
    for (int i = 0; i < DB + 2; i++) hist.push_back('0);
  endtask

  task automatic model_edge(input logic r, input logic w, input logic [AW-1:0] a,
                            input logic [31:0] d, input logic [GW-1:0] g);
    logic [GW-1:0] ev;
    logic [GW-1:0] nf;
    logic          rising;
    logic          flip;
    int            ch;
    if (!r) begin
      model_reset();
      return;
    end
    for (int b = 0; b < GW; b++) begin
      rising = m_edge[b / W][b % W];
      ev[b] = rising ? (!m_prev[b] && m_filt[b]) : (m_prev[b] && !m_filt[b]);
    end
`ifdef GPIO_DEBOUNCE_EN
    for (int b = 0; b < GW; b++) begin
      flip = 1'b1;
      for (int j = 1; j <= DB; j++) if (hist[j][b] == m_filt[b]) flip = 1'b0;
      nf[b] = flip ? !m_filt[b] : m_filt[b];
    end
`else
    flip = 1'b0;
    nf = hist[0];
`endif
    ch = int'(a >> 3);
    if (w && ch < NCH) begin
      case (a[2:0])
        3'd1: m_dout[ch] = d;
        3'd2: m_dout[ch] = m_dout[ch] | d;
        3'd3: m_dout[ch] = m_dout[ch] & ~d;
        3'd4: m_mask[ch] = d;
        3'd5: m_edge[ch] = d;
        3'd6: m_stat[ch] = m_stat[ch] & ~d;
        default: ;
      endcase
    end
    for (int c = 0; c < NCH; c++) m_stat[c] = m_stat[c] | ev[c*W +: W];
    m_prev = m_filt;
    m_filt = nf;
    hist.push_front(g);
    void'(hist.pop_back());
  endtask

  function automatic logic [GW-1:0] m_gpo();
    logic [GW-1:0] v;
    for (int c = 0; c < NCH; c++) v[c*W +: W] = m_dout[c];
    return v;
  endfunction

  function automatic logic m_irq();
    logic v = 1'b0;
    for (int c = 0; c < NCH; c++) v = v | (|(m_stat[c] & m_mask[c]));
    return v;
  endfunction

  function automatic logic [31:0] m_read(input logic [AW-1:0] a);
    int ch = int'(a >> 3);
    if (ch >= NCH) return '0;
    case (a[2:0])
      3'd0: return m_filt[ch*W +: W];
      3'd1: return m_dout[ch];
      3'd4: return m_mask[ch];
      3'd5: return m_edge[ch];
      3'd6: return m_stat[ch];
      default: return '0;
    endcase
  endfunction

  // One clock: drive inputs, step the model on the edge, compare just after.
  task automatic cycle(input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [31:0] d, input logic [GW-1:0] g);
    rst = r; we = w; addr = a; wd = d; gpi = g;
    @(posedge clk);
    model_edge(r, w, a, d, g);
    #1;
    chk("model_gpo", gpo, m_gpo());
    chk("model_irq", 64'(irq), 64'(m_irq()));
    chk("model_rd", 64'(rd), 64'(m_read(a)));
  endtask

  typedef struct {
    logic          r;
    logic          w;
    logic [AW-1:0] a;
    logic [31:0]   d;
    logic [GW-1:0] g;
    logic [31:0]   erd;
    logic [GW-1:0] egpo;
    logic          eirq;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic w, input logic [AW-1:0] a,
                              input logic [31:0] d, input logic [GW-1:0] g,
                              input logic [31:0] erd, input logic [GW-1:0] egpo,
                              input logic eirq);
    vec_t v;
    v.r = r; v.w = w; v.a = a; v.d = d; v.g = g;
    v.erd = erd; v.egpo = egpo; v.eirq = eirq;
    return v;
  endfunction

  localparam logic [63:0] O    = 64'h0;
  localparam logic [63:0] G5   = 64'h5;
  localparam logic [63:0] G7   = 64'h7;
  localparam logic [63:0] G7H  = 64'h0000_0001_0000_0007;
  localparam logic [63:0] G6H  = 64'h0000_0001_0000_0006;
  localparam logic [63:0] GA   = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] P78  = 64'h0000_0000_0000_0078;
  localparam logic [63:0] P78F = 64'h0000_000F_0000_0078;
  localparam logic [63:0] PA   = 64'h0000_000A_0000_0078;
  localparam logic [31:0] F32  = 32'hFFFF_FFFF;
  localparam int NV = 44;

  vec_t tv [NV];

  initial begin
    logic [GW-1:0] g;
    int            idx;
    logic          r;
    logic          w;
    logic [AW-1:0] a;
    logic [31:0]   d;

    rst = 1'b0; we = 1'b0; addr = '0; wd = '0; gpi = '0;
    model_reset();

    tv[0]  = mk(0, 0, 1,  32'h0,    O,   32'h0,  O,    0);
    tv[1]  = mk(0, 1, 1,  32'hFFFF, O,   32'h0,  O,    0);
    tv[2]  = mk(1, 1, 1,  32'h78,   O,   32'h78, P78,  0);
    tv[3]  = mk(1, 1, 10, 32'h0F,   O,   32'h0,  P78F, 0);
    tv[4]  = mk(1, 1, 11, 32'h05,   O,   32'h0,  PA,   0);
    tv[5]  = mk(1, 0, 9,  32'h0,    O,   32'h0A, PA,   0);
    tv[6]  = mk(1, 1, 7,  F32,      O,   32'h0,  PA,   0);
    tv[7]  = mk(1, 1, 0,  F32,      O,   32'h0,  PA,   0);
    tv[8]  = mk(1, 0, 0,  32'h0,    G5,  32'h0,  PA,   0);
    tv[9]  = mk(1, 0, 0,  32'h0,    G5,  32'h5,  PA,   0);
    tv[10] = mk(1, 0, 0,  32'h0,    G7,  32'h5,  PA,   0);
    tv[11] = mk(1, 0, 0,  32'h0,    G7,  32'h7,  PA,   0);
    tv[12] = mk(1, 1, 12, 32'h1,    G7,  32'h1,  PA,   0);
    tv[13] = mk(1, 1, 13, 32'h1,    G7,  32'h1,  PA,   0);
    tv[14] = mk(1, 0, 14, 32'h0,    G7H, 32'h0,  PA,   0);
    tv[15] = mk(1, 0, 14, 32'h0,    G7H, 32'h0,  PA,   0);
    tv[16] = mk(1, 0, 14, 32'h0,    G7H, 32'h1,  PA,   1);
    tv[17] = mk(1, 1, 14, 32'h1,    G7H, 32'h0,  PA,   0);
    tv[18] = mk(1, 0, 14, 32'h0,    G7H, 32'h0,  PA,   0);
    tv[19] = mk(1, 1, 4,  32'h1,    G7H, 32'h1,  PA,   0);
    tv[20] = mk(1, 0, 6,  32'h0,    G6H, 32'h0,  PA,   0);
    tv[21] = mk(1, 0, 6,  32'h0,    G6H, 32'h0,  PA,   0);
    tv[22] = mk(1, 0, 6,  32'h0,    G6H, 32'h1,  PA,   1);
    tv[23] = mk(1, 1, 6,  32'h1,    G6H, 32'h0,  PA,   0);
    tv[24] = mk(1, 0, 6,  32'h0,    G7H, 32'h0,  PA,   0);
    tv[25] = mk(1, 0, 6,  32'h0,    G7H, 32'h0,  PA,   0);
    tv[26] = mk(1, 0, 6,  32'h0,    G7H, 32'h0,  PA,   0);
    tv[27] = mk(1, 0, 6,  32'h0,    G6H, 32'h0,  PA,   0);
    tv[28] = mk(1, 0, 6,  32'h0,    G6H, 32'h0,  PA,   0);
    tv[29] = mk(1, 0, 6,  32'h0,    G6H, 32'h1,  PA,   1);
    tv[30] = mk(1, 0, 6,  32'h0,    G7H, 32'h1,  PA,   1);
    tv[31] = mk(1, 0, 6,  32'h0,    G7H, 32'h1,  PA,   1);
    tv[32] = mk(1, 0, 6,  32'h0,    G6H, 32'h1,  PA,   1);
    tv[33] = mk(1, 0, 6,  32'h0,    G6H, 32'h1,  PA,   1);
    tv[34] = mk(1, 1, 6,  32'h1,    G6H, 32'h1,  PA,   1);
    tv[35] = mk(1, 0, 6,  32'h0,    G6H, 32'h1,  PA,   1);
    tv[36] = mk(1, 1, 17, F32,      G6H, 32'h0,  PA,   1);
    tv[37] = mk(0, 0, 6,  32'h0,    GA,  32'h0,  O,    0);
    tv[38] = mk(0, 0, 6,  32'h0,    GA,  32'h0,  O,    0);
    tv[39] = mk(1, 1, 5,  F32,      GA,  F32,    O,    0);
    tv[40] = mk(1, 0, 6,  32'h0,    GA,  32'h0,  O,    0);
    tv[41] = mk(1, 0, 6,  32'h0,    GA,  F32,    O,    0);
    tv[42] = mk(1, 0, 14, 32'h0,    GA,  32'h0,  O,    0);
    tv[43] = mk(1, 0, 0,  32'h0,    GA,  F32,    O,    0);

`ifndef GPIO_DEBOUNCE_EN
    for (int i = 0; i < NV; i++) begin
      cycle(tv[i].r, tv[i].w, tv[i].a, tv[i].d, tv[i].g);
      chk($sformatf("vec%0d_rd", i), 64'(rd), 64'(tv[i].erd));
      chk($sformatf("vec%0d_gpo", i), gpo, tv[i].egpo);
      chk($sformatf("vec%0d_irq", i), 64'(irq), 64'(tv[i].eirq));
    end
`else
    cycle(0, 0, 0, 0, O);
    cycle(0, 0, 0, 0, O);
    cycle(1, 1, 5, 1, O);
    cycle(1, 1, 4, 1, O);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 64'h1);
    for (int i = 0; i < 8; i++) begin
      cycle(1, 0, 0, 0, O);
      chk($sformatf("db_pulse_din%0d", i), 64'(rd), 64'h0);
    end
    cycle(1, 0, 6, 0, O);
    chk("db_pulse_stat", 64'(rd), 64'h0);
    for (int i = 0; i < 6; i++) begin
      cycle(1, 0, 0, 0, 64'h1);
      chk($sformatf("db_stable_din%0d", i), 64'(rd), (i == 5) ? 64'h1 : 64'h0);
    end
    for (int i = 0; i < 3; i++) cycle(1, 0, 6, 0, 64'h1);
    chk("db_stable_stat", 64'(rd), 64'h1);
    chk("db_stable_irq", 64'(irq), 64'h1);
`endif

    g = '0;
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 2) == 0) begin
        idx = int'($urandom_range(0, GW - 1));
        g[idx] = ~g[idx];
      end
      a = AW'($urandom_range(0, (1 << AW) - 1));
      w = 1'($urandom_range(0, 1));
      d = $urandom();
      cycle(r, w, a, d, g);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
